prco_led_pwm_bank: RTL and testbench

//  Memory-mapped LED driver for the xc6lx9_msp board top; replaces the static LEDS[7:0] output.

---
 rtl/prco_led_pwm_bank_pkg.sv | 32 +++
 rtl/prco_led_pwm_bank_prescaler.sv | 45 ++++
 rtl/prco_led_pwm_bank.sv | 148 ++++++++++++++
 tb/tb_prco_led_pwm_bank.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prco_led_pwm_bank_pkg.sv
// Shared definitions for the PRCO LED PWM bank.
//   - Register word addresses (DIV, MODE, first DUTY slot)
//   - Per-channel mode encoding
//   - led_level(): maps a channel mode plus frame state to an output level
package prco_led_pwm_bank_pkg;

  localparam int LED_A_DIV   = 0;
  localparam int LED_A_MODE  = 1;
  localparam int LED_A_DUTY0 = 2;

  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    LED_M_OFF   = 2'b00,
    LED_M_ON    = 2'b01,
    LED_M_PWM   = 2'b10,
    LED_M_BLINK = 2'b11
  } led_mode_e;

  function automatic logic led_level(input led_mode_e mode, input logic pwm_hi,
                                     input logic blink);
    logic lvl;
    case (mode)
      LED_M_ON:    lvl = 1'b1;
      LED_M_PWM:   lvl = pwm_hi;
      LED_M_BLINK: lvl = blink;
      default:     lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/prco_led_pwm_bank_prescaler.sv
// Programmable tick prescaler (also usable as a UART baud generator).
//   clk50    in   system clock
//   rst_n    in   async active-low reset
//   i_wr     in   load strobe: takes i_wdata as new reload, restarts the count
//   i_wdata  in   DIV_BITS new reload value
//   o_div    out  DIV_BITS current reload value (for readback)
//   o_tick   out  1-cycle pulse while count == reload; period is DIV+1 cycles
module prco_led_pwm_bank_prescaler #(
  parameter int DIV_BITS    = 16,
  parameter int DIV_DEFAULT = 195
) (
  input  logic                clk50,
  input  logic                rst_n,
  input  logic                i_wr,
  input  logic [DIV_BITS-1:0] i_wdata,
  output logic [DIV_BITS-1:0] o_div,
  output logic                o_tick
);

  logic [DIV_BITS-1:0] r_div;
  logic [DIV_BITS-1:0] r_cnt;
  logic                w_tick;

  // Combinational tick: DIV=0 keeps the count at 0, so it fires every cycle.
  assign w_tick = (r_cnt == r_div);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= DIV_BITS'(DIV_DEFAULT);
      r_cnt <= '0;
    end else if (i_wr) begin
      // New reload restarts the period from the write edge.
      r_div <= i_wdata;
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_BITS'(1);
    end
  end

  assign o_div  = r_div;
  assign o_tick = w_tick;

endmodule

// File: rtl/prco_led_pwm_bank.sv
// Memory-mapped LED driver: NUM_CH channels, each OFF / ON / PWM / BLINK.
//   clk50      in   system clock
//   rst_n      in   async active-low reset (release synchronised internally)
//   bus_addr   in   ADDR_W word address: 0 DIV, 1 MODE, 2+i DUTY[i]
//   bus_wr     in   write strobe, commits on the edge it is high
//   bus_rd     in   read strobe; data returned the following cycle
//   bus_wdata  in   16-bit write data
//   bus_rdata  out  16-bit read data, holds until the next read
//   bus_rvalid out  1-cycle pulse the cycle after bus_rd
//   leds       out  NUM_CH registered LED levels, active high
module prco_led_pwm_bank
  import prco_led_pwm_bank_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int PWM_BITS    = 8,
  parameter int DIV_BITS    = 16,
  parameter int DIV_DEFAULT = 195,
  parameter int ADDR_W      = 4
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [BUS_W-1:0]  bus_wdata,
  output logic [BUS_W-1:0]  bus_rdata,
  output logic              bus_rvalid,
  output logic [NUM_CH-1:0] leds
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  // Async assert, sync release.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Register file
  logic [2*NUM_CH-1:0]              r_mode;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  r_duty;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  r_shadow;
  logic [DIV_BITS-1:0]              w_div;
  logic                             w_wr_div;
  logic                             w_wr_mode;
  logic [BUS_W-1:0]                 w_rd_val;
  logic [BUS_W-1:0]                 r_rdata;
  logic                             r_rvalid;

  assign w_wr_div  = bus_wr && (bus_addr == ADDR_W'(LED_A_DIV));
  assign w_wr_mode = bus_wr && (bus_addr == ADDR_W'(LED_A_MODE));

  always_ff @(posedge clk50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_mode <= '0;
      r_duty <= '0;
    end else begin
      if (w_wr_mode) r_mode <= bus_wdata[2*NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++)
        if (bus_wr && (bus_addr == ADDR_W'(LED_A_DUTY0 + i)))
          r_duty[i] <= bus_wdata[PWM_BITS-1:0];
    end
  end

  // Read mux sees pre-edge state, so rd+wr in one cycle returns the old value.
  always_comb begin
    w_rd_val = '0;
    if (bus_addr == ADDR_W'(LED_A_DIV))       w_rd_val[DIV_BITS-1:0] = w_div;
    else if (bus_addr == ADDR_W'(LED_A_MODE)) w_rd_val[2*NUM_CH-1:0] = r_mode;
    for (int i = 0; i < NUM_CH; i++)
      if (bus_addr == ADDR_W'(LED_A_DUTY0 + i)) w_rd_val[PWM_BITS-1:0] = r_duty[i];
  end

  always_ff @(posedge clk50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus_rd;
      if (bus_rd) r_rdata <= w_rd_val;
    end
  end

  assign bus_rdata  = r_rdata;
  assign bus_rvalid = r_rvalid;

  // Prescaler
  logic w_tick;

  prco_led_pwm_bank_prescaler #(
    .DIV_BITS    (DIV_BITS),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_presc (
    .clk50   (clk50),
    .rst_n   (w_rst_n),
    .i_wr    (w_wr_div),
    .i_wdata (bus_wdata[DIV_BITS-1:0]),
    .o_div   (w_div),
    .o_tick  (w_tick)
  );

  // Frame counter; duty is latched into the shadow only at frame start
  // so a mid-frame duty write never produces a runt pulse.
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_blink;
  logic                w_wrap;

  assign w_wrap = w_tick && (r_pwm_cnt == PWM_MAX);

  always_ff @(posedge clk50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pwm_cnt <= '0;
      r_shadow  <= '0;
      r_blink   <= 1'b0;
    end else begin
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (w_wrap) begin
        r_shadow <= r_duty;
        r_blink  <= ~r_blink;
      end
    end
  end

  // Per-channel output comparators
  logic [NUM_CH-1:0] w_led_nxt;
  logic [NUM_CH-1:0] r_leds;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_led_nxt[g] = led_level(led_mode_e'(r_mode[2*g +: 2]),
                                    r_pwm_cnt < r_shadow[g], r_blink);
  end

  always_ff @(posedge clk50 or negedge w_rst_n) begin
    if (!w_rst_n) r_leds <= '0;
    else          r_leds <= w_led_nxt;
  end

  assign leds = r_leds;

  // Upper write-data bits beyond the narrowest field are intentionally dropped.
  logic w_unused_wdata;
  assign w_unused_wdata = ^bus_wdata;

endmodule

// File: tb/tb_prco_led_pwm_bank.sv
module tb_prco_led_pwm_bank;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic [3:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_rvalid;
  logic [7:0]  leds;

  int checks   = 0;
  int failures = 0;

  always #10 clk50 = ~clk50;

  prco_led_pwm_bank dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_wr     (bus_wr),
    .bus_rd     (bus_rd),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .leds       (leds)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk50);
    bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
    @(negedge clk50);
    bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d, output logic v);
    @(negedge clk50);
    bus_addr = a; bus_rd = 1'b1;
    @(negedge clk50);
    bus_rd = 1'b0;
    d = bus_rdata; v = bus_rvalid;
  endtask

  task automatic read_check(input string nm, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] d;
    logic        v;
    bus_read(a, d, v);
    check({nm, " rvalid"}, 32'(v), 32'd1);
    check({nm, " rdata"}, 32'(d), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk50);
    rst_n = 1'b0;
    @(negedge clk50);
    rst_n = 1'b1;
    repeat (3) @(negedge clk50);
  endtask

  task automatic count_high(input int ch, input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk50);
      c += int'(leds[ch]);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic        v;
    int          c;
    int          hi0, hi1;
    bit          found;
    logic        prev;
    int          t_gap, bad;
    int          first, second;

    vecs[0]  = '{0, 4'd0,  16'h0000, 16'd195};
    vecs[1]  = '{0, 4'd1,  16'h0000, 16'h0000};
    vecs[2]  = '{0, 4'd2,  16'h0000, 16'h0000};
    vecs[3]  = '{1, 4'd1,  16'hFFFF, 16'h0000};
    vecs[4]  = '{0, 4'd1,  16'h0000, 16'hFFFF};
    vecs[5]  = '{1, 4'd2,  16'h1234, 16'h0000};
    vecs[6]  = '{0, 4'd2,  16'h0000, 16'h0034};
    vecs[7]  = '{1, 4'd9,  16'hABCD, 16'h0000};
    vecs[8]  = '{0, 4'd9,  16'h0000, 16'h00CD};
    vecs[9]  = '{1, 4'd10, 16'h5555, 16'h0000};
    vecs[10] = '{0, 4'd10, 16'h0000, 16'h0000};
    vecs[11] = '{1, 4'd15, 16'h1234, 16'h0000};
    vecs[12] = '{0, 4'd15, 16'h0000, 16'h0000};
    vecs[13] = '{1, 4'd0,  16'hBEEF, 16'h0000};
    vecs[14] = '{0, 4'd0,  16'h0000, 16'hBEEF};
    vecs[15] = '{0, 4'd3,  16'h0000, 16'h0000};

    rst_n = 1'b0; bus_addr = '0; bus_wr = 1'b0; bus_rd = 1'b0; bus_wdata = '0;
    repeat (3) @(negedge clk50);
    check("reset leds", 32'(leds), 32'h0);
    check("reset rdata", 32'(bus_rdata), 32'h0);
    check("reset rvalid", 32'(bus_rvalid), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk50);

    // Register map vectors
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else            read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Simultaneous rd+wr returns the old value; rvalid is a single pulse
    do_reset();
    bus_write(4'd2, 16'h0011);
    @(negedge clk50);
    bus_addr = 4'd2; bus_wdata = 16'h0077; bus_wr = 1'b1; bus_rd = 1'b1;
    @(negedge clk50);
    bus_wr = 1'b0; bus_rd = 1'b0;
    check("rdwr old rvalid", 32'(bus_rvalid), 32'd1);
    check("rdwr old rdata", 32'(bus_rdata), 32'h11);
    @(negedge clk50);
    check("rvalid pulse low", 32'(bus_rvalid), 32'd0);
    check("rdata hold", 32'(bus_rdata), 32'h11);
    read_check("rdwr new", 4'd2, 16'h0077);

    // Async reset mid-frame with all channels ON
    bus_write(4'd1, 16'h5555);
    repeat (3) @(negedge clk50);
    check("all on", 32'(leds), 32'hFF);
    #2 rst_n = 1'b0;
    #1 check("async reset leds", 32'(leds), 32'h0);
    @(negedge clk50);
    rst_n = 1'b1;
    repeat (3) @(negedge clk50);
    read_check("post-reset DIV", 4'd0, 16'd195);
    read_check("post-reset MODE", 4'd1, 16'h0000);

    // PWM with DIV=0: 256-cycle frame
    bus_write(4'd0, 16'd0);
    bus_write(4'd1, 16'h0002);
    bus_write(4'd2, 16'd64);
    repeat (600) @(negedge clk50);
    count_high(0, 256, c);
    check("pwm duty64", 32'(c), 32'd64);
    bus_write(4'd2, 16'd0);
    repeat (600) @(negedge clk50);
    count_high(0, 256, c);
    check("pwm duty0", 32'(c), 32'd0);
    bus_write(4'd2, 16'd255);
    repeat (600) @(negedge clk50);
    count_high(0, 256, c);
    check("pwm duty255", 32'(c), 32'd255);

    // Mid-frame duty change applies only from the next frame
    bus_write(4'd2, 16'd64);
    repeat (600) @(negedge clk50);
    found = 1'b0;
    for (int w = 0; w < 700 && !found; w++) begin
      prev = leds[0];
      @(negedge clk50);
      if (!prev && leds[0]) found = 1'b1;
    end
    check("frame start found", 32'(found), 32'd1);
    hi0 = int'(leds[0]); hi1 = 0;
    for (int k = 1; k < 512; k++) begin
      if (k == 10) begin bus_addr = 4'd2; bus_wdata = 16'd192; bus_wr = 1'b1; end
      if (k == 11) bus_wr = 1'b0;
      if (k == 20) begin bus_addr = 4'd2; bus_rd = 1'b1; end
      if (k == 21) bus_rd = 1'b0;
      @(negedge clk50);
      if (k == 20) begin
        check("duty readback rvalid", 32'(bus_rvalid), 32'd1);
        check("duty readback immediate", 32'(bus_rdata), 32'd192);
      end
      if (k < 256) hi0 += int'(leds[0]);
      else         hi1 += int'(leds[0]);
    end
    check("current frame duty", 32'(hi0), 32'd64);
    check("next frame duty", 32'(hi1), 32'd192);

    // Mixed modes, DIV=3 -> 1024-cycle frame
    bus_write(4'd0, 16'd3);
    bus_write(4'd1, 16'h00E4);
    repeat (4) @(negedge clk50);
    bad = 0;
    found = 1'b0;
    for (int w = 0; w < 1100 && !found; w++) begin
      prev = leds[3];
      @(negedge clk50);
      if (leds[1] !== 1'b1 || leds[0] !== 1'b0) bad++;
      if (leds[3] != prev) found = 1'b1;
    end
    check("blink edge found", 32'(found), 32'd1);
    found = 1'b0; t_gap = 0;
    for (int w = 0; w < 1100 && !found; w++) begin
      prev = leds[3];
      @(negedge clk50);
      t_gap++;
      if (leds[1] !== 1'b1 || leds[0] !== 1'b0) bad++;
      if (leds[3] != prev) found = 1'b1;
    end
    check("blink period", 32'(t_gap), 32'd1024);
    check("on/off channels steady", 32'(bad), 32'd0);

    // DIV rewrite mid-count restarts the period at the write edge
    bus_write(4'd0, 16'd20);
    repeat (7) @(negedge clk50);
    @(negedge clk50);
    bus_addr = 4'd0; bus_wdata = 16'd9; bus_wr = 1'b1;
    @(negedge clk50);
    bus_wr = 1'b0;
    first = -1; second = -1;
    for (int k = 0; k < 25; k++) begin
      if (dut.u_presc.o_tick) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      @(negedge clk50);
    end
    check("first tick after DIV write", 32'(first), 32'd9);
    check("second tick after DIV write", 32'(second), 32'd19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
